// File: rtl/led_pattern_gen.sv
// Runtime-selectable LED pattern engine: blink, chase, bounce and PWM breathe.
// A prescaler paces pattern steps; mode changes re-initialise the pattern.
module led_pattern_gen #(
  parameter int NUM_LEDS    = 4,
  parameter int STEP_CYCLES = 50_000_000,
  parameter int PWM_BITS    = 8,
  parameter int DUTY_STEP   = 1
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_tick
);

  localparam int PW = $clog2(STEP_CYCLES);
  localparam logic [PW-1:0] PRE_TC = PW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS:0] DSTEP = (PWM_BITS+1)'(DUTY_STEP);
  localparam logic [PWM_BITS:0] DMAX = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [PWM_BITS-1:0] DSTEP_N = DSTEP[PWM_BITS-1:0];

  typedef enum logic [1:0] {
    M_BLINK   = 2'b00,
    M_CHASE   = 2'b01,
    M_BOUNCE  = 2'b10,
    M_BREATHE = 2'b11
  } mode_e;

  logic [PW-1:0]       pre, pre_d;
  logic [NUM_LEDS-1:0] pat, pat_d, led_d;
  logic [NUM_LEDS-1:0] shl, shr;
  logic                dir_up, dir_up_d;
  logic                ddir_up, ddir_up_d;
  logic [PWM_BITS-1:0] duty, duty_d, pwm_cnt;
  logic [PWM_BITS:0]   up_sum;
  logic [1:0]          mode_q;
  logic                init_pend;
  logic                init, tick;

  assign init   = init_pend || (mode != mode_q);
  assign tick   = !init && !pause && (pre == PRE_TC);
  assign up_sum = {1'b0, duty} + DSTEP;
  assign shl    = {pat[NUM_LEDS-2:0], 1'b0};
  assign shr    = {1'b0, pat[NUM_LEDS-1:1]};

  always_comb begin
    pre_d     = pre;
    pat_d     = pat;
    dir_up_d  = dir_up;
    duty_d    = duty;
    ddir_up_d = ddir_up;
    if (init) begin
      pre_d     = '0;
      dir_up_d  = 1'b1;
      ddir_up_d = 1'b1;
      duty_d    = '0;
      pat_d     = '0;
      if (mode == M_CHASE || mode == M_BOUNCE)
        pat_d = NUM_LEDS'(1);
    end else if (!pause) begin
      pre_d = tick ? '0 : pre + PW'(1);
      if (tick) begin
        unique case (1'b1)
          mode_q == M_BLINK: pat_d = ~pat;
          mode_q == M_CHASE:
            pat_d = {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
          mode_q == M_BOUNCE: begin
            // Turn around on arrival so endpoints show only once
            if (dir_up) begin
              pat_d = shl;
              if (shl[NUM_LEDS-1]) dir_up_d = 1'b0;
            end else begin
              pat_d = shr;
              if (shr[0]) dir_up_d = 1'b1;
            end
          end
          mode_q == M_BREATHE: begin
            if (ddir_up) begin
              if (up_sum >= DMAX) begin
                duty_d    = '1;
                ddir_up_d = 1'b0;
              end else begin
                duty_d = up_sum[PWM_BITS-1:0];
              end
            end else begin
              if ({1'b0, duty} <= DSTEP) begin
                duty_d    = '0;
                ddir_up_d = 1'b1;
              end else begin
                duty_d = duty - DSTEP_N;
              end
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    led_d = pat;
    if (mode_q == M_BREATHE)
      led_d = {NUM_LEDS{pwm_cnt < duty}};
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      pre       <= '0;
      pat       <= '0;
      dir_up    <= 1'b1;
      duty      <= '0;
      ddir_up   <= 1'b1;
      pwm_cnt   <= '0;
      mode_q    <= 2'b00;
      init_pend <= 1'b1;
      led       <= '0;
      step_tick <= 1'b0;
    end else begin
      pre       <= pre_d;
      pat       <= pat_d;
      dir_up    <= dir_up_d;
      duty      <= duty_d;
      ddir_up   <= ddir_up_d;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      mode_q    <= mode;
      init_pend <= 1'b0;
      led       <= led_d;
      step_tick <= tick;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scenario bench for led_pattern_gen with a small prescaler.
// Expected LED values are queued per scenario and drained at each step.
module tb_led_pattern_gen;

  localparam int NL = 4;
  localparam int SC = 10;
  localparam int PB = 4;
  localparam int DS = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    mode = 2'b01;
  logic [NL-1:0] led;
  logic          step_tick;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int e0 = 0;
  int tcyc = 0;
  bit found;
  logic [NL-1:0] exp_q[$];
  int duty_q[$];

  led_pattern_gen #(
    .NUM_LEDS(NL),
    .STEP_CYCLES(SC),
    .PWM_BITS(PB),
    .DUTY_STEP(DS)
  ) dut (
    .sys_clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .pause(pause),
    .led(led),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_tick(input int lim);
    found = 0;
    for (int k = 0; k < lim && !found; k++) begin
      @(negedge clk);
      if (step_tick === 1'b1) begin
        found = 1;
        tcyc = cyc;
      end
    end
  endtask

  task automatic test_reset;
    logic [NL-1:0] ev;
    rst_n = 1'b0;
    mode = 2'b01;
    repeat (5) @(negedge clk);
    n_checks++;
    if (led !== 4'b0000 || step_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: led=%b tick=%b, expected 0000/0", led, step_tick);
    end
    rst_n = 1'b1;
    @(negedge clk);
    e0 = cyc;
    n_checks++;
    if (led !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_e0_led: led=%b, expected 0000", led);
    end
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0001 || step_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL chase_init: led=%b tick=%b, expected 0001/0", led, step_tick);
    end
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int i = 0; i < 4; i++) begin
      wait_tick(SC + 5);
      n_checks++;
      if (!found || tcyc != e0 + SC * (i + 1)) begin
        n_fail++;
        $display("FAIL chase_tick%0d: at cycle %0d, expected %0d", i, tcyc - e0, SC * (i + 1));
      end
      @(negedge clk);
      ev = exp_q.pop_front();
      n_checks++;
      if (led !== ev) begin
        n_fail++;
        $display("FAIL chase_step%0d: led=%b, expected %b", i, led, ev);
      end
    end
  endtask

  task automatic test_bounce;
    logic [NL-1:0] ev;
    mode = 2'b10;
    @(negedge clk);
    e0 = cyc;
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0001) begin
      n_fail++;
      $display("FAIL bounce_init: led=%b, expected 0001", led);
    end
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 7; i++) begin
      wait_tick(SC + 5);
      n_checks++;
      if (!found || tcyc != e0 + SC * (i + 1)) begin
        n_fail++;
        $display("FAIL bounce_tick%0d: at cycle %0d, expected %0d", i, tcyc - e0, SC * (i + 1));
      end
      @(negedge clk);
      ev = exp_q.pop_front();
      n_checks++;
      if (led !== ev) begin
        n_fail++;
        $display("FAIL bounce_step%0d: led=%b, expected %b", i, led, ev);
      end
    end
  endtask

  task automatic test_blink;
    logic [NL-1:0] ev;
    mode = 2'b00;
    @(negedge clk);
    e0 = cyc;
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0000) begin
      n_fail++;
      $display("FAIL blink_init: led=%b, expected 0000", led);
    end
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0000);
    for (int i = 0; i < 4; i++) begin
      wait_tick(SC + 5);
      n_checks++;
      if (!found || tcyc != e0 + SC * (i + 1)) begin
        n_fail++;
        $display("FAIL blink_tick%0d: at cycle %0d, expected %0d", i, tcyc - e0, SC * (i + 1));
      end
      @(negedge clk);
      ev = exp_q.pop_front();
      n_checks++;
      if (led !== ev || step_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL blink_step%0d: led=%b tick=%b, expected %b/0", i, led, step_tick, ev);
      end
    end
  endtask

  task automatic test_breathe;
    int on;
    int ed;
    mode = 2'b11;
    @(negedge clk);
    pause = 1'b1;
    duty_q.push_back(0);
    duty_q.push_back(5);
    duty_q.push_back(10);
    duty_q.push_back(15);
    duty_q.push_back(10);
    duty_q.push_back(5);
    duty_q.push_back(0);
    duty_q.push_back(5);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        wait_tick(SC + 5);
        pause = 1'b1;
        n_checks++;
        if (!found) begin
          n_fail++;
          $display("FAIL breathe_tick%0d: no tick, expected one within %0d cycles", i, SC + 5);
        end
      end
      @(negedge clk);
      on = 0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (led === 4'b1111) on++;
      end
      ed = duty_q.pop_front();
      n_checks++;
      if (on != ed) begin
        n_fail++;
        $display("FAIL breathe_duty%0d: on %0d of 16, expected %0d", i, on, ed);
      end
      pause = 1'b0;
    end
  endtask

  task automatic test_pause;
    mode = 2'b01;
    @(negedge clk);
    e0 = cyc;
    repeat (4) @(negedge clk);
    pause = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      n_checks++;
      if (step_tick !== 1'b0 || led !== 4'b0001) begin
        n_fail++;
        $display("FAIL pause_hold%0d: led=%b tick=%b, expected 0001/0", k, led, step_tick);
      end
    end
    pause = 1'b0;
    wait_tick(SC + 5);
    n_checks++;
    if (!found || tcyc != e0 + SC + 25) begin
      n_fail++;
      $display("FAIL pause_resume_tick: at cycle %0d, expected %0d", tcyc - e0, SC + 25);
    end
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0010) begin
      n_fail++;
      $display("FAIL pause_resume_led: led=%b, expected 0010", led);
    end
  endtask

  task automatic test_back_to_back;
    int r;
    repeat (3) @(negedge clk);
    mode = 2'b10;
    @(negedge clk);
    e0 = cyc;
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0001) begin
      n_fail++;
      $display("FAIL switch_init: led=%b, expected 0001", led);
    end
    wait_tick(SC + 5);
    n_checks++;
    if (!found || tcyc != e0 + SC) begin
      n_fail++;
      $display("FAIL switch_tick: at cycle %0d, expected %0d", tcyc - e0, SC);
    end
    wait_tick(SC + 5);
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0100) begin
      n_fail++;
      $display("FAIL switch_step2: led=%b, expected 0100", led);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0000 || step_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_led: led=%b tick=%b, expected 0000/0", led, step_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e0 = cyc;
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_init: led=%b, expected 0001", led);
    end
    wait_tick(SC + 5);
    n_checks++;
    if (!found || tcyc != e0 + SC) begin
      n_fail++;
      $display("FAIL midreset_tick: at cycle %0d, expected %0d", tcyc - e0, SC);
    end
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0010) begin
      n_fail++;
      $display("FAIL midreset_step: led=%b, expected 0010", led);
    end
    repeat (2) @(negedge clk);
    mode = 2'b01;
    pause = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0001) begin
      n_fail++;
      $display("FAIL pause_switch_init: led=%b, expected 0001", led);
    end
    wait_tick(20);
    n_checks++;
    if (found) begin
      n_fail++;
      $display("FAIL pause_switch_hold: tick at cycle %0d, expected none", tcyc);
    end
    pause = 1'b0;
    r = cyc;
    wait_tick(SC + 5);
    n_checks++;
    if (!found || tcyc != r + SC) begin
      n_fail++;
      $display("FAIL pause_switch_tick: at cycle %0d, expected %0d", tcyc - r, SC);
    end
    @(negedge clk);
    n_checks++;
    if (led !== 4'b0010) begin
      n_fail++;
      $display("FAIL pause_switch_step: led=%b, expected 0010", led);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_blink();
    test_breathe();
    test_pause();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine, successor to the fixed 4-LED blinker. Drives `NUM_LEDS` outputs in one of four runtime-selectable modes: blink, chase, bounce and PWM breathe. Pattern steps are timed by an internal prescaler. Sits directly between board I/O and the `sys_clk` domain, with optional mode/pause control from switches or a CPU register.

## Interface

- `NUM_LEDS`, 4: LED count; must be ≥ 2.
- `STEP_CYCLES`, 50_000_000: `sys_clk` cycles per pattern step (0.5 s at 100 MHz); must be ≥ 2. Benches override it small.
- `PWM_BITS`, 8: breathe PWM counter/duty width.
- `DUTY_STEP`, 1: duty increment per step in breathe mode; must be ≥ 1 and < 2^`PWM_BITS`.

- `sys_clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `mode`  in  2: 00 blink, 01 chase, 10 bounce, 11 breathe; sampled every cycle.
- `pause`  in  1: high freezes pattern progress.
- `led`  out  `NUM_LEDS`: registered LED drive, 1 = on.
- `step_tick`  out  1: registered one-cycle pulse on each pattern step.

## Operation

- Prescaler `pre` runs 0..`STEP_CYCLES`-1, width clog2(`STEP_CYCLES`).
  - At terminal count: wraps to 0, `step_tick` pulses, pattern register advances.
- Pattern register `pat[NUM_LEDS-1:0]`, plus `dir` (bounce) and `duty[PWM_BITS-1:0]`/`ddir` (breathe).
- Init event (first cycle after `rst_n` rises, or any cycle where `mode` ≠ `mode_q`):
  - Clears `pre`, registers `mode_q` ← `mode`, loads the mode's init state.
  - No tick is issued in the init cycle.
- Blink: init `pat` = all 0; each step `pat` ← ~`pat`.
- Chase: init `pat` = one-hot bit 0; each step rotate left; MSB wraps to bit 0.
- Bounce: init `pat` = bit 0, `dir` = up.
  - Each step shifts one position in `dir`; direction reverses on reaching bit `NUM_LEDS`-1 or bit 0.
  - Endpoints are not repeated. For 4 LEDs: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010…
- Breathe: init `duty` = 0, `ddir` = up.
  - Each step while up: `duty` += `DUTY_STEP`, saturating at 2^`PWM_BITS`-1; on saturation `ddir` ← down.
  - Down: `duty` -= `DUTY_STEP`, saturating at 0; on reaching 0 `ddir` ← up.
  - Free-running `pwm_cnt` (`PWM_BITS`, wraps); `led` ← all bits = (`pwm_cnt` < `duty`).
- Non-breathe modes: `led` ← `pat`.
- Pause:
  - `pre`, `pat`, `dir`, `duty` and `ddir` hold; `step_tick` stays 0.
  - `pwm_cnt` keeps running, so breathe holds its current brightness.
  - Pause with a mode change in the same cycle: init still occurs; the prescaler stays at 0 until pause drops.
- Reset mid-pattern: all state returns to reset values at the next edge with `rst_n` = 0, regardless of mode or pause.

## Timing

- Reset values: `led` = 0, `step_tick` = 0, `pre` = 0, `pat` = 0, `duty` = 0, `pwm_cnt` = 0, `dir`/`ddir` = up, `mode_q` = 00, init-pending = 1.
- Init cycle (edge E0): `pat`/`duty` loaded; `led` shows init pattern at E0+1.
  - Chase/bounce: 0001 at E0+1. Blink: 0.
- First `step_tick` at E0 + `STEP_CYCLES`; then every `STEP_CYCLES` cycles while unpaused.
- `step_tick` rises on the same edge that `pat` advances; `led` shows the new pattern one cycle later.
- Breathe `led` lags `pwm_cnt`/`duty` by one register stage.
- PWM period is 2^`PWM_BITS` cycles.
  - `duty` = 0 → LEDs always off.
  - `duty` = max → LEDs on for (2^`PWM_BITS`-1) of 2^`PWM_BITS` cycles.
- Pause taking effect: `pause` high at an edge where `pre` is at terminal count suppresses that tick.

## Test plan

Test parameters: `STEP_CYCLES` = 10, `PWM_BITS` = 4, `NUM_LEDS` = 4.

- Reset held 5 cycles, mode = 01, release → `led` = 0 through E0, 0001 at E0+1; ticks at E0+10, +20, +30, +40; `led` sequence 0010, 0100, 1000, 0001 (wrap).
- Mode = 10 → `led` shows 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 over 7 ticks; no repeated endpoint.
- Mode = 00 → `led` alternates 0000/1111 every 10 cycles; `step_tick` exactly 1 cycle wide.
- Mode = 11, `DUTY_STEP` = 5 → `duty` sequence 0, 5, 10, 15 (sat), 10, 5, 0, 5; at `duty` = 10, `led` on 10 of every 16 cycles; at 0, never on.
- Pause asserted for 25 cycles mid-chase → no ticks and `led` frozen; after release, next tick after the remaining prescaler count.
- Mode switch 01 → 10 mid-step, and `rst_n` low mid-bounce → immediate reinit to 0001 with prescaler restart; reset drives `led` = 0 the cycle after `rst_n` is sampled low.
